// File: rtl/otter_dcache.sv
// otter_dcache: direct-mapped, write-through, no-write-allocate data cache between the OTTER CPU and memory.
// Loads hit with zero latency; misses refill 8-word lines; addresses at or above MMIO_BASE bypass the cache.
module otter_dcache #(
   parameter int          LINES     = 16,
   parameter int          WORDS     = 8,
   parameter logic [31:0] MMIO_BASE = 32'h00010000
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        CPU_RDEN,
   input  logic        CPU_WE,
   input  logic [31:0] CPU_ADDR,
   input  logic [31:0] CPU_DIN,
   input  logic [1:0]  CPU_SIZE,
   input  logic        CPU_SIGN,
   output logic [31:0] CPU_DOUT,
   output logic        CPU_STALL,
   output logic        MEM_REQ,
   output logic        MEM_WE,
   output logic [31:0] MEM_ADDR,
   output logic [31:0] MEM_DIN,
   output logic [1:0]  MEM_SIZE,
   output logic        MEM_SIGN,
   input  logic [31:0] MEM_DOUT,
   input  logic        MEM_ACK
);
   localparam int IW = $clog2(LINES);
   localparam int TW = 27 - IW;
   typedef enum logic [1:0] {IDLE, REFILL, WTHRU, UNCACHED} state_t;
   state_t            state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic              done_q, done_d, byp_q, byp_d;
   logic [31:0]       hold_q, hold_d;
   logic [LINES-1:0]  valid_q;
   logic [TW-1:0]     tag_q [LINES];
   logic [31:0]       data_q [LINES*WORDS];
   logic [IW-1:0]     idx;
   logic [TW-1:0]     tag;
   logic [2:0]        wrd;
   logic [1:0]        off;
   logic              hit, mmio, fill_we, fill_last, merge_we;
   logic [31:0]       cur;
   assign off  = CPU_ADDR[1:0];
   assign wrd  = CPU_ADDR[4:2];
   assign idx  = CPU_ADDR[4+IW:5];
   assign tag  = CPU_ADDR[31:5+IW];
   assign cur  = data_q[{idx, wrd}];
   assign hit  = valid_q[idx] && (tag_q[idx] == tag);
   assign mmio = CPU_ADDR >= MMIO_BASE;
   function automatic logic [31:0] ld_ext(input logic [31:0] w, input logic [1:0] o, input logic [1:0] sz, input logic sg);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[{o, 3'b000} +: 8];
      h = o[1] ? w[31:16] : w[15:0];
      return (sz == 2'd0) ? {{24{b[7] & ~sg}}, b} :
             (sz == 2'd1 && !o[0]) ? {{16{h[15] & ~sg}}, h} :
             (sz == 2'd2 && o == 2'd0) ? w : 32'h0;
   endfunction
   function automatic logic [31:0] st_merge(input logic [31:0] w, input logic [31:0] d, input logic [1:0] o, input logic [1:0] sz);
      logic [31:0] r;
      r = w;
      if (sz == 2'd0) r[{o, 3'b000} +: 8] = d[7:0];
      else if (sz == 2'd1 && !o[0]) r[{o[1], 4'b0000} +: 16] = d[15:0];
      else if (sz == 2'd2 && o == 2'd0) r = d;
      return r;
   endfunction
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      done_d    = 1'b0;
      byp_d     = 1'b0;
      hold_d    = hold_q;
      CPU_STALL = 1'b0;
      CPU_DOUT  = 32'h0;
      MEM_REQ   = 1'b0;
      MEM_WE    = 1'b0;
      MEM_ADDR  = CPU_ADDR;
      MEM_DIN   = CPU_DIN;
      MEM_SIZE  = CPU_SIZE;
      MEM_SIGN  = CPU_SIGN;
      fill_we   = 1'b0;
      fill_last = 1'b0;
      merge_we  = 1'b0;
      case (state_q)
         IDLE: begin
            // done_q marks the cycle a finished store/uncached access is released
            if (done_q) CPU_DOUT = byp_q ? hold_q : 32'h0;
            else if ((CPU_RDEN || CPU_WE) && mmio) begin
               CPU_STALL = 1'b1;
               state_d   = UNCACHED;
            end else if (CPU_WE) begin
               CPU_STALL = 1'b1;
               state_d   = WTHRU;
            end else if (CPU_RDEN && hit) CPU_DOUT = ld_ext(cur, off, CPU_SIZE, CPU_SIGN);
            else if (CPU_RDEN) begin
               CPU_STALL = 1'b1;
               state_d   = REFILL;
               cnt_d     = 3'd0;
            end
         end
         REFILL: begin
            CPU_STALL = 1'b1;
            MEM_REQ   = 1'b1;
            MEM_ADDR  = {CPU_ADDR[31:5], cnt_q, 2'b00};
            MEM_SIZE  = 2'd2;
            MEM_SIGN  = 1'b0;
            if (MEM_ACK) begin
               fill_we   = 1'b1;
               cnt_d     = cnt_q + 3'd1;
               fill_last = cnt_q == 3'd7;
               state_d   = (cnt_q == 3'd7) ? IDLE : REFILL;
            end
         end
         WTHRU: begin
            CPU_STALL = 1'b1;
            MEM_REQ   = 1'b1;
            MEM_WE    = 1'b1;
            if (MEM_ACK) begin
               merge_we = hit;
               done_d   = 1'b1;
               state_d  = IDLE;
            end
         end
         default: begin
            CPU_STALL = 1'b1;
            MEM_REQ   = 1'b1;
            MEM_WE    = CPU_WE;
            if (MEM_ACK) begin
               hold_d  = MEM_DOUT;
               done_d  = 1'b1;
               byp_d   = 1'b1;
               state_d = IDLE;
            end
         end
      endcase
      if (!RST_N) begin
         CPU_STALL = 1'b0;
         CPU_DOUT  = 32'h0;
         MEM_REQ   = 1'b0;
         MEM_WE    = 1'b0;
         fill_we   = 1'b0;
         fill_last = 1'b0;
         merge_we  = 1'b0;
      end
   end
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q <= IDLE;
         cnt_q   <= 3'd0;
         done_q  <= 1'b0;
         byp_q   <= 1'b0;
         hold_q  <= 32'h0;
         valid_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         byp_q   <= byp_d;
         hold_q  <= hold_d;
         // line is invalid while partially refilled
         if (fill_we) valid_q[idx] <= fill_last;
      end
   end
   always_ff @(posedge CLK) begin
      if (fill_we) data_q[{idx, cnt_q}] <= MEM_DOUT;
      if (fill_last) tag_q[idx] <= tag;
      if (merge_we) data_q[{idx, wrd}] <= st_merge(cur, CPU_DIN, off, CPU_SIZE);
   end
endmodule

// File: doc/otter_dcache.md
Name: otter_dcache

Overview:
- Direct-mapped, write-through, no-write-allocate data cache.
- Sits between the OTTER CPU data port (loads and stores) and the data port of the OTTER memory.
- Hits return sized and sign-extended load data in the request cycle. Misses stall the CPU while 8-word lines refill through a req/ack handshake.
- Addresses at or above 0x00010000 (MMIO) bypass the cache and are forwarded uncached.

Parameters:
- LINES, 16, number of cache lines; power of two, range 2..256.
- WORDS, 8, words per line; fixed at 8, matching the instruction-cache line size.
- MMIO_BASE, 32'h00010000, first uncached address.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RST_N  input  1  synchronous active-low reset.
- CPU_RDEN  input  1  load request.
- CPU_WE  input  1  store request; CPU_RDEN and CPU_WE asserted together is illegal.
- CPU_ADDR  input  32  byte address.
- CPU_DIN  input  32  store data, right-aligned.
- CPU_SIZE  input  2  0 byte, 1 half, 2 word.
- CPU_SIGN  input  1  1 unsigned, 0 signed.
- CPU_DOUT  output  32  sized and extended load data.
- CPU_STALL  output  1  CPU must hold the request and its PC.
- MEM_REQ  output  1  backing-memory request.
- MEM_WE  output  1  backing write.
- MEM_ADDR  output  32  backing byte address.
- MEM_DIN  output  32  backing write data.
- MEM_SIZE  output  2  backing access size.
- MEM_SIGN  output  1  backing sign mode.
- MEM_DOUT  input  32  backing read data; valid with MEM_ACK.
- MEM_ACK  input  1  one-cycle completion pulse per request.

Behaviour:
- Address split: offset[1:0], word[4:2], index[4+log2(LINES):5], tag = remaining upper bits.
- Storage per line: valid bit, tag, 8x32 data.
- Reset (RST_N=0 at posedge):
  - all valid bits cleared; state goes to IDLE.
  - MEM_REQ, MEM_WE and CPU_STALL are 0; CPU_DOUT is 0.
  - Reset wins over any in-progress refill or write; the partial line stays invalid.
  - Data arrays are not cleared.
- States: IDLE, REFILL, WTHRU, UNCACHED.
- IDLE, no request: stall 0, MEM_REQ 0.
- IDLE, cached load hit (valid && tag match):
  - CPU_DOUT comes combinationally from the line word, sized and extended with the same byte/half/offset table as the memory port.
  - Unsupported SIZE/offset combinations return 0.
  - Stall 0; zero added latency.
- IDLE, cached load miss:
  - stall 1 combinationally; go to REFILL; refill counter cleared to 0.
- REFILL:
  - MEM_REQ=1, MEM_WE=0, MEM_SIZE=2, MEM_SIGN=0, MEM_ADDR={tag,index,counter,2'b00}.
  - Each MEM_ACK writes MEM_DOUT into data[counter] and increments the counter.
  - Request stays asserted between beats.
  - On the ACK with counter==7: set valid, write tag, return to IDLE.
  - The held request then hits the next cycle.
  - Minimum miss penalty is 9 cycles with single-cycle ACK.
- IDLE, cached store (hit or miss): stall 1, go to WTHRU.
- WTHRU:
  - MEM_REQ=1, MEM_WE=1; MEM_ADDR, MEM_DIN, MEM_SIZE taken from the CPU inputs.
  - On MEM_ACK: if the line hit, merge the bytes selected by SIZE/offset into the cached word; a miss does not allocate. Return to IDLE.
  - The next cycle, stall falls for that request. A one-cycle done flag (set on ACK, cleared next cycle) suppresses re-issue.
- Any request with CPU_ADDR >= MMIO_BASE: stall 1, go to UNCACHED.
- UNCACHED:
  - CPU signals pass through to the MEM_* outputs.
  - On MEM_ACK, MEM_DOUT is captured into a holding register, the done flag is set, and the state returns to IDLE.
  - The next cycle, CPU_DOUT is the holding register, unmodified (memory has already sized it), and stall is 0.
  - Cache state is unchanged.
- MEM_ACK outside a request is ignored.
- The CPU must keep its inputs stable while CPU_STALL=1.

Test Plan:
- Reset, then load word at 0x100 (memory 0x100..0x11C = 0xA0..0xA7) -> 8 reads at 0x100,0x104,...,0x11C with SIZE=2; stall for 9 cycles; CPU_DOUT=0xA0; a following lw 0x11C hits with 0 stall and returns 0xA7.
- Line cached, sb 0x80 to 0x105 -> one MEM write (SIZE=0, addr 0x105, din 0x80); then lb 0x105 hits and returns 0xFFFFFF80, and lbu 0x105 returns 0x00000080.
- Conflict: cache 0x100, then load 0x300 (same index, LINES=16) -> refill at 0x300; a later load from 0x100 misses again and refills.
- Store to uncached line 0x400, then load 0x400 -> the write causes no fill; the load refills and returns the stored word.
- lw 0x11000000 with memory ACK data 0x1234 -> one pass-through request; returns 0x1234; no cache line changes.
- RST_N low during refill beat 4, then load 0x100 again -> full 8-beat refill repeats from counter 0; no stale hit.
